// File: rtl/ysyx_23060124_dmem_responder_if.sv
// LSU data-memory bus: simplified AXI4-Lite AR/R and AW/W/B channels.
// The master side is the LSU; the slave side is the memory responder.
interface ysyx_23060124_dmem_responder_if;
    logic [31:0] i_araddr;
    logic        i_arvalid;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rvalid;
    logic        i_rready;
    logic [31:0] i_awaddr;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;

    modport slave (
        input  i_araddr,
        input  i_arvalid,
        output o_arready,
        output o_rdata,
        output o_rresp,
        output o_rvalid,
        input  i_rready,
        input  i_awaddr,
        input  i_awvalid,
        output o_awready,
        input  i_wdata,
        input  i_wstrb,
        input  i_wvalid,
        output o_wready,
        output o_bresp,
        output o_bvalid,
        input  i_bready
    );

    modport master (
        output i_araddr,
        output i_arvalid,
        input  o_arready,
        input  o_rdata,
        input  o_rresp,
        input  o_rvalid,
        output i_rready,
        output i_awaddr,
        output i_awvalid,
        input  o_awready,
        output i_wdata,
        output i_wstrb,
        output i_wvalid,
        input  o_wready,
        input  o_bresp,
        input  o_bvalid,
        output i_bready
    );
endinterface

// File: rtl/ysyx_23060124_dmem_responder.sv
// Data-memory responder: word array behind an AXI4-Lite-style slave port.
// One transaction in flight, fixed LAT wait cycles before each response.
module ysyx_23060124_dmem_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned LAT   = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    ysyx_23060124_dmem_responder_if.slave bus
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [2:0]    state;
    logic [3:0]    cnt;
    logic          cnt_done;

    logic          hit_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic          rvalid_q;
    logic [1:0]    bresp_q;
    logic          bvalid_q;

    logic          wr_req;
    logic          wr_acc;
    logic          rd_acc;
    logic [31:0]   req_addr;
    logic [31:0]   req_off;
    logic          req_hit;
    logic [IW-1:0] req_idx;
    logic          mem_we;

    logic [31:0]   mem [DEPTH];

    // Request acceptance and address decode of whichever request wins IDLE.
    always_comb begin
        wr_req   = bus.i_awvalid & bus.i_wvalid;
        wr_acc   = (state == IDLE) & wr_req;
        rd_acc   = (state == IDLE) & ~wr_req & bus.i_arvalid;
        req_addr = wr_req ? bus.i_awaddr : bus.i_araddr;
        req_off  = req_addr - BASE;
        req_hit  = (req_addr >= BASE) && ({1'b0, req_off} < SPAN);
        req_idx  = req_off[IW+1:2];
        cnt_done = (cnt == 4'd0);
        mem_we   = i_rst_n & (state == WR_WAIT) & cnt_done & hit_q;
    end

    assign bus.o_awready = wr_acc;
    assign bus.o_wready  = wr_acc;
    assign bus.o_arready = (state == IDLE) & ~wr_req;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_rresp   = rresp_q;
    assign bus.o_rvalid  = rvalid_q;
    assign bus.o_bresp   = bresp_q;
    assign bus.o_bvalid  = bvalid_q;

    // Capture the decoded request; only meaningful while a transaction is open.
    always_ff @(posedge clk) begin
        if (wr_acc | rd_acc) begin
            hit_q   <= req_hit;
            idx_q   <= req_idx;
            wdata_q <= bus.i_wdata;
            wstrb_q <= bus.i_wstrb;
        end
    end

    // Byte-lane array update on the edge that enters WR_RESP; never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with latency counter and registered responses.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata_q  <= 32'd0;
            rresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            bvalid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_acc) begin
                        state <= WR_WAIT;
                        cnt   <= 4'(LAT);
                    end else if (rd_acc) begin
                        state <= RD_WAIT;
                        cnt   <= 4'(LAT);
                    end
                end
                RD_WAIT: begin
                    if (cnt_done) begin
                        state    <= RD_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= hit_q ? mem[idx_q] : 32'd0;
                        rresp_q  <= hit_q ? OKAY : SLVERR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (bus.i_rready) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (cnt_done) begin
                        state    <= WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= hit_q ? OKAY : SLVERR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (bus.i_bready) begin
                        state    <= IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_dmem_responder.sv
// Bench for the data-memory responder: vector table plus hand sequences,
// with a response scoreboard fed at issue time and drained on responses.
module tb_ysyx_23060124_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060124_dmem_responder_if bus();

    ysyx_23060124_dmem_responder #(
        .DEPTH(1024),
        .BASE(32'h8000_0000),
        .LAT(LAT)
    ) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.i_araddr  = '0;
        bus.i_arvalid = 1'b0;
        bus.i_rready  = 1'b0;
        bus.i_awaddr  = '0;
        bus.i_awvalid = 1'b0;
        bus.i_wdata   = '0;
        bus.i_wstrb   = '0;
        bus.i_wvalid  = 1'b0;
        bus.i_bready  = 1'b0;
    endtask

    task automatic wait_r(input string name);
        int lat = 0;
        while (!bus.o_rvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " r latency"}, 32'(lat), 32'(LAT + 1));
    endtask

    task automatic wait_b(input string name);
        int lat = 0;
        while (!bus.o_bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " b latency"}, 32'(lat), 32'(LAT + 1));
    endtask

    task automatic check_r(input string name);
        exp_t e;
        if (exp_q.size() == 0 || exp_q[0].wr) begin
            errors++;
            $display("FAIL %s: unexpected read response %h", name,
                     bus.o_rdata);
            return;
        end
        e = exp_q.pop_front();
        chk({name, " rdata"}, bus.o_rdata, e.data);
        chk({name, " rresp"}, 32'(bus.o_rresp), 32'(e.resp));
    endtask

    task automatic check_b(input string name);
        exp_t e;
        if (exp_q.size() == 0 || !exp_q[0].wr) begin
            errors++;
            $display("FAIL %s: unexpected write response %h", name,
                     bus.o_bresp);
            return;
        end
        e = exp_q.pop_front();
        chk({name, " bresp"}, 32'(bus.o_bresp), 32'(e.resp));
    endtask

    task automatic ack_r(input string name);
        bus.i_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_rready = 1'b0;
        chk({name, " rvalid clear"}, 32'(bus.o_rvalid), 32'd0);
    endtask

    task automatic ack_b(input string name);
        bus.i_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_bready = 1'b0;
        chk({name, " bvalid clear"}, 32'(bus.o_bvalid), 32'd0);
    endtask

    task automatic wait_accept(input string name, input bit wr);
        int n = 0;
        #1;
        while (!(wr ? bus.o_awready : bus.o_arready) && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 64) begin
            errors++;
            $display("FAIL %s: handshake timeout got 0 want 1", name);
        end
    endtask

    task automatic do_read(input string name, input logic [31:0] addr,
                           input logic [31:0] d, input logic [1:0] resp);
        exp_q.push_back('{1'b0, d, resp});
        bus.i_araddr  = addr;
        bus.i_arvalid = 1'b1;
        wait_accept(name, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        wait_r(name);
        check_r(name);
        ack_r(name);
    endtask

    task automatic do_write(input string name, input logic [31:0] addr,
                            input logic [31:0] d, input logic [3:0] strb,
                            input logic [1:0] resp);
        exp_q.push_back('{1'b1, 32'd0, resp});
        bus.i_awaddr  = addr;
        bus.i_wdata   = d;
        bus.i_wstrb   = strb;
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        wait_accept(name, 1'b1);
        chk({name, " wready"}, 32'(bus.o_wready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        wait_b(name);
        check_b(name);
        ack_b(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          bcount;

        vecs.push_back('{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});
        vecs.push_back('{1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00});
        vecs.push_back('{1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10});
        vecs.push_back('{1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 2'b10});
        vecs.push_back('{0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00});
        vecs.push_back('{1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00});
        vecs.push_back('{0, 32'h8000_0013, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});
        vecs.push_back('{1, 32'h8000_0FFE, 32'h0BAD_CAFE, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00});
        vecs.push_back('{0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 2'b10});
        vecs.push_back('{1, 32'h8000_0044, 32'h0000_0000, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1, 32'h8000_0044, 32'h5566_7788, 4'hA, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h8000_0044, 32'h0, 4'h0, 32'h5500_7700, 2'b00});

        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("reset bvalid", 32'(bus.o_bvalid), 32'd0);
        chk("reset rdata", bus.o_rdata, 32'd0);
        chk("reset rresp", 32'(bus.o_rresp), 32'd0);
        chk("reset bresp", 32'(bus.o_bresp), 32'd0);
        chk("reset arready", 32'(bus.o_arready), 32'd1);
        chk("reset awready", 32'(bus.o_awready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lone AW must never be accepted
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 32'h8000_0000;
        #1;
        chk("lone aw awready", 32'(bus.o_awready), 32'd0);
        chk("lone aw arready", 32'(bus.o_arready), 32'd1);
        @(negedge clk);
        bus.i_awvalid = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata,
                         vecs[i].strb, vecs[i].exp_resp);
            end else begin
                do_read($sformatf("vec%0d", i), vecs[i].addr,
                        vecs[i].exp_data, vecs[i].exp_resp);
            end
        end

        // simultaneous read and write: write wins, read sees new data
        @(negedge clk);
        exp_q.push_back('{1'b1, 32'd0, 2'b00});
        exp_q.push_back('{1'b0, 32'h5A5A_A5A5, 2'b00});
        bus.i_araddr  = 32'h8000_0040;
        bus.i_arvalid = 1'b1;
        bus.i_awaddr  = 32'h8000_0040;
        bus.i_wdata   = 32'h5A5A_A5A5;
        bus.i_wstrb   = 4'hF;
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        #1;
        chk("sim awready", 32'(bus.o_awready), 32'd1);
        chk("sim wready", 32'(bus.o_wready), 32'd1);
        chk("sim arready", 32'(bus.o_arready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        #1;
        chk("sim arready wait", 32'(bus.o_arready), 32'd0);
        wait_b("sim");
        check_b("sim");
        chk("sim arready bresp", 32'(bus.o_arready), 32'd0);
        ack_b("sim");
        #1;
        chk("sim arready idle", 32'(bus.o_arready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        wait_r("sim");
        check_r("sim");
        ack_r("sim");

        // backpressure: hold rready low for 5 cycles
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 2'b00});
        bus.i_araddr  = 32'h8000_0010;
        bus.i_arvalid = 1'b1;
        wait_accept("bp", 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        wait_r("bp");
        check_r("bp");
        held = bus.o_rdata;
        exp_q.push_back('{1'b0, 32'h11BB_33DD, 2'b00});
        bus.i_araddr  = 32'h8000_0020;
        bus.i_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d rvalid", k), 32'(bus.o_rvalid), 32'd1);
            chk($sformatf("bp%0d rdata", k), bus.o_rdata, held);
            chk($sformatf("bp%0d arready", k), 32'(bus.o_arready), 32'd0);
        end
        bus.i_rready = 1'b1;
        #1;
        chk("bp arready at rready", 32'(bus.o_arready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.i_rready = 1'b0;
        #1;
        chk("bp rvalid after", 32'(bus.o_rvalid), 32'd0);
        chk("bp arready after", 32'(bus.o_arready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        wait_r("bp2");
        check_r("bp2");
        ack_r("bp2");

        // reset right after a write handshake discards the write
        do_write("rstw pre", 32'h8000_0050, 32'h0102_0304, 4'hF, 2'b00);
        bus.i_awaddr  = 32'h8000_0050;
        bus.i_wdata   = 32'hFFFF_FFFF;
        bus.i_wstrb   = 4'hF;
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        #1;
        chk("rstw awready", 32'(bus.o_awready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.o_bvalid) bcount++;
        end
        chk("rstw bvalid count", 32'(bcount), 32'd0);
        do_read("rstw readback", 32'h8000_0050, 32'h0102_0304, 2'b00);

        // reset while a read response is pending
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 2'b00});
        bus.i_araddr  = 32'h8000_0010;
        bus.i_arvalid = 1'b1;
        wait_accept("rstr", 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        wait_r("rstr");
        check_r("rstr");
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstr rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("rstr rdata", bus.o_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rstr arready", 32'(bus.o_arready), 32'd1);
        do_read("rstr after", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
